aes_key_schedule_ctrl: RTL and testbench

// - Sequences AES-128 key expansion and owns round-key storage: 11 round keys, 44 x 32-bit words.
// - Captures the cipher key one column per cycle during the main FSM's KEY_WRITE phase.
// - Expands one word per clock, then raises key_expand_done to release the main FSM from COMPUTE_ROUNDKEYS.
// - Serves a zero-latency column read port to the AddRoundKey datapath, indexed by round and column.

---
 rtl/aes_pkg.sv | 9 +
 rtl/aes_sbox.sv | 25 ++
 rtl/aes_key_schedule_ctrl.sv | 64 ++++++
 tb/tb_aes_key_schedule_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants, state encoding and GF(2^8) helper for the AES key schedule.
package aes_pkg;
  typedef enum logic [1:0] {KS_IDLE = 2'd0, KS_LOAD = 2'd1, KS_EXPAND = 2'd2, KS_DONE = 2'd3} ks_state_t;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int NUM_WORDS = 44;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES forward S-box lookup.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  assign y = SBOX[a];
endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// aes_key_schedule_ctrl: AES-128 key expansion sequencer with 44-word round-key store and zero-latency read port.
module aes_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10,
  parameter int WORD_W     = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              key_start,
  input  logic [WORD_W-1:0] key_word_in,
  input  logic [3:0]        rk_round,
  input  logic [1:0]        rk_col,
  output logic [WORD_W-1:0] rk_word,
  output logic              key_expand_done,
  output logic              busy,
  output logic [1:0]        dbg_state,
  output logic [5:0]        dbg_word_idx
);
  ks_state_t state;
  logic [5:0] word_idx;
  logic [7:0] rcon;
  logic [WORD_W-1:0] w [NUM_WORDS];
  logic [WORD_W-1:0] prev, rot, sub, temp;
  assign prev = w[word_idx - 6'd1];
  assign rot = {prev[WORD_W-9:0], prev[WORD_W-1 -: 8]};
  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[WORD_W-1-8*g -: 8]), .y(sub[WORD_W-1-8*g -: 8]));
  end
  assign temp = (word_idx[1:0] == 2'd0) ? sub ^ {rcon, 24'h0} : prev;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= KS_IDLE;
      word_idx <= '0;
      rcon <= RCON_INIT;
      key_expand_done <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) w[i] <= '0;
    end else if (key_start) begin
      w[0] <= key_word_in;
      rcon <= RCON_INIT;
      word_idx <= 6'd1;
      state <= KS_LOAD;
      key_expand_done <= 1'b0;
    end else if (state == KS_LOAD) begin
      w[word_idx] <= key_word_in;
      word_idx <= word_idx + 6'd1;
      state <= (word_idx == 6'd3) ? KS_EXPAND : KS_LOAD;
    end else if (state == KS_EXPAND) begin
      w[word_idx] <= w[word_idx - 6'd4] ^ temp;
      rcon <= (word_idx[1:0] == 2'd0) ? xtime(rcon) : rcon;
      // index parks at the last word so dbg_word_idx never leaves 0..43
      if (word_idx == 6'(NUM_WORDS - 1)) begin
        state <= KS_DONE;
        key_expand_done <= 1'b1;
      end else begin
        word_idx <= word_idx + 6'd1;
      end
    end
  end
  assign rk_word = (rk_round <= 4'(NUM_ROUNDS)) ? w[{rk_round, rk_col}] : '0;
  assign busy = (state == KS_LOAD) || (state == KS_EXPAND);
  assign dbg_state = state;
  assign dbg_word_idx = word_idx;
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// tb_aes_key_schedule_ctrl: directed self-checking bench for the AES-128 key schedule controller.
module tb_aes_key_schedule_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic key_start = 1'b0;
  logic [31:0] key_word_in = '0;
  logic [3:0] rk_round = '0;
  logic [1:0] rk_col = '0;
  logic [31:0] rk_word;
  logic key_expand_done, busy;
  logic [1:0] dbg_state;
  logic [5:0] dbg_word_idx;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [3:0]  KR [10] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd10, 4'd10, 4'd10, 4'd10};
  localparam logic [1:0]  KC [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
  localparam logic [31:0] KW [10] = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
                                      32'ha0fafe17, 32'h88542cb1,
                                      32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6};

  aes_key_schedule_ctrl dut (
    .clock(clock), .reset_n(reset_n), .key_start(key_start), .key_word_in(key_word_in),
    .rk_round(rk_round), .rk_col(rk_col), .rk_word(rk_word), .key_expand_done(key_expand_done),
    .busy(busy), .dbg_state(dbg_state), .dbg_word_idx(dbg_word_idx)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_key(input logic [127:0] k);
    key_start = 1'b1;
    key_word_in = k[127:96];
    tick();
    key_start = 1'b0;
    for (int c = 1; c < 4; c++) begin
      key_word_in = k[127-32*c -: 32];
      tick();
    end
    key_word_in = '0;
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_cmp++;
    if ({key_expand_done, busy, dbg_state, dbg_word_idx} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_status: got done=%b busy=%b state=%0d idx=%0d want all 0", key_expand_done, busy, dbg_state, dbg_word_idx);
    end
    for (int i = 0; i < 2; i++) begin
      rk_round = i ? 4'd10 : 4'd0;
      rk_col = i ? 2'd3 : 2'd0;
      #1;
      n_cmp++;
      if (rk_word !== 32'h0) begin
        n_err++;
        $display("FAIL reset_word r%0d c%0d: got %h want 00000000", rk_round, rk_col, rk_word);
      end
    end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_fips();
    start_key(FIPS_KEY);
    repeat (40) tick();
    n_cmp++;
    if (key_expand_done !== 1'b1 || dbg_state !== 2'd3) begin
      n_err++;
      $display("FAIL fips_done: got done=%b state=%0d want done=1 state=3", key_expand_done, dbg_state);
    end
    for (int i = 0; i < 10; i++) begin
      rk_round = KR[i];
      rk_col = KC[i];
      #1;
      n_cmp++;
      if (rk_word !== KW[i]) begin
        n_err++;
        $display("FAIL fips_word r%0d c%0d: got %h want %h", KR[i], KC[i], rk_word, KW[i]);
      end
    end
  endtask

  task automatic test_latency_zero_key();
    logic [3:0]  zr [5] = '{4'd1, 4'd1, 4'd10, 4'd10, 4'd11};
    logic [1:0]  zc [5] = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd2};
    logic [31:0] zw [5] = '{32'h62636363, 32'h62636363, 32'hb4ef5bcb, 32'h6f8f188e, 32'h00000000};
    key_start = 1'b1;
    key_word_in = '0;
    for (int e = 0; e < 43; e++) begin
      tick();
      key_start = 1'b0;
      n_cmp++;
      if (busy !== 1'b1 || key_expand_done !== 1'b0) begin
        n_err++;
        $display("FAIL latency_E%0d: got busy=%b done=%b want busy=1 done=0", e, busy, key_expand_done);
      end
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || key_expand_done !== 1'b1) begin
      n_err++;
      $display("FAIL latency_E43: got busy=%b done=%b want busy=0 done=1", busy, key_expand_done);
    end
    for (int i = 0; i < 5; i++) begin
      rk_round = zr[i];
      rk_col = zc[i];
      #1;
      n_cmp++;
      if (rk_word !== zw[i]) begin
        n_err++;
        $display("FAIL zero_key r%0d c%0d: got %h want %h", zr[i], zc[i], rk_word, zw[i]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] ew [8] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                            32'h13111d7f, 32'he3944a17, 32'hf307a78b, 32'h4d2b30c5};
    start_key(FIPS_KEY);
    repeat (16) tick();
    start_key(SEQ_KEY);
    repeat (39) tick();
    n_cmp++;
    if (key_expand_done !== 1'b0) begin
      n_err++;
      $display("FAIL abort_early_done: got %b want 0", key_expand_done);
    end
    tick();
    n_cmp++;
    if (key_expand_done !== 1'b1) begin
      n_err++;
      $display("FAIL abort_done: got %b want 1", key_expand_done);
    end
    for (int i = 0; i < 8; i++) begin
      rk_round = (i < 4) ? 4'd0 : 4'd10;
      rk_col = 2'(i % 4);
      #1;
      n_cmp++;
      if (rk_word !== ew[i]) begin
        n_err++;
        $display("FAIL abort_word r%0d c%0d: got %h want %h", rk_round, rk_col, rk_word, ew[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    start_key(FIPS_KEY);
    repeat (10) tick();
    reset_n = 1'b0;
    #2;
    n_cmp++;
    if ({key_expand_done, busy, dbg_state, dbg_word_idx} !== 10'd0) begin
      n_err++;
      $display("FAIL midreset_status: got done=%b busy=%b state=%0d idx=%0d want all 0", key_expand_done, busy, dbg_state, dbg_word_idx);
    end
    for (int r = 0; r < 11; r++) begin
      for (int c = 0; c < 4; c++) begin
        rk_round = 4'(r);
        rk_col = 2'(c);
        #0.1;
        n_cmp++;
        if (rk_word !== 32'h0) begin
          n_err++;
          $display("FAIL midreset_word r%0d c%0d: got %h want 00000000", r, c, rk_word);
        end
      end
    end
    tick();
    reset_n = 1'b1;
    tick();
    test_fips();
  endtask

  task automatic test_hold();
    int j;
    logic [31:0] exp_w;
    for (int n = 0; n < 100; n++) begin
      j = $urandom_range(0, 11);
      rk_round = (j < 10) ? KR[j] : (j == 10 ? 4'd11 : 4'd15);
      rk_col = (j < 10) ? KC[j] : 2'($urandom_range(0, 3));
      exp_w = (j < 10) ? KW[j] : 32'h0;
      #1;
      n_cmp++;
      if (rk_word !== exp_w || key_expand_done !== 1'b1) begin
        n_err++;
        $display("FAIL hold_%0d r%0d c%0d: got %h done=%b want %h done=1", n, rk_round, rk_col, rk_word, key_expand_done, exp_w);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_latency_zero_key();
    test_abort();
    test_reset_mid();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
